// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load result code and the data-memory access FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_W      = 2'b01;
  localparam logic [1:0] FWD_M      = 2'b10;
  localparam logic [1:0] RESULT_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERROR
  } mem_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle of the hazard controller: register indices and
// control in, forwarding selects and stall/flush enables out.
interface hazard_controller_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5
);

  logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]                ResultSrcE;
  logic                      RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM;
  logic [1:0]                ForwardAE, ForwardBE;
  logic                      StallF, StallD, StallE, StallM;
  logic                      FlushD, FlushE, FlushW;
  logic                      MemBusy, MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemBusy, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemBusy, MemTimeout
  );

endinterface

// File: rtl/hazard_controller_forwarding_unit.sv
// Combinational ALU operand forwarding: the younger M-stage result wins
// over W; register x0 is never forwarded.
module forwarding_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b
);

  function automatic logic [1:0] select(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))
      return FWD_M;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = select(rs1);
    fwd_b = select(rs2);
  end

endmodule

// File: rtl/hazard_controller.sv
// Central pipeline scheduler: forwarding, load-use and branch hazards, and a
// req/ack sequencer with watchdog for multi-cycle data-memory accesses in M.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mem_timeout;
  logic             mem_stall;
  logic             lw_stall;
  logic [1:0]       fwd_a, fwd_b;

  forwarding_unit #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd (
    .rs1        (hz.Rs1E),
    .rs2        (hz.Rs2E),
    .rd_m       (hz.RdM),
    .rd_w       (hz.RdW),
    .reg_write_m(hz.RegWriteM),
    .reg_write_w(hz.RegWriteW),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state_next == ERROR)
        mem_timeout <= 1'b1;
    end
  end

  // The counter holds the number of stall cycles already spent on this access,
  // so an ack arriving while it equals TIMEOUT_CYCLES is still accepted.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (hz.MemReqM && !hz.MemAckM) begin
          mem_stall  = 1'b1;
          cnt_next   = CNT_W'(1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (hz.MemAckM) begin
          state_next = IDLE;
        end else begin
          mem_stall = 1'b1;
          if (cnt == CNT_W'(TIMEOUT_CYCLES))
            state_next = ERROR;
          else
            cnt_next = cnt + CNT_W'(1);
        end
      end
      ERROR:   mem_stall = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign lw_stall = (hz.ResultSrcE == RESULT_MEM) && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (rst) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushW = 1'b1;
    end else if (mem_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (lw_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  assign hz.ForwardAE  = rst ? FWD_RF : fwd_a;
  assign hz.ForwardBE  = rst ? FWD_RF : fwd_b;
  assign hz.MemBusy    = !rst && (state != IDLE);
  assign hz.MemTimeout = mem_timeout;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, hand-written
// memory/timeout/reset sequences, then random traffic against a reference model.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned TO = 4;

  typedef struct {
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]    rsrc;
    logic          rwm, rww, pcs, req, ack;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [1:0] fa, fb;
    logic [6:0] ctl;   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  } vec_t;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LW   = 7'b1100010;
  localparam logic [6:0] C_RST  = 7'b0000111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if #(.REG_ADDR_WIDTH(AW)) bus ();

  hazard_controller #(
    .REG_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];
  in_t  v, idle;
  int   waited;
  bit   dead;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW};
  endfunction

  task automatic apply(input in_t i);
    bus.Rs1D = i.rs1d; bus.Rs2D = i.rs2d; bus.Rs1E = i.rs1e; bus.Rs2E = i.rs2e;
    bus.RdE = i.rde; bus.RdM = i.rdm; bus.RdW = i.rdw; bus.ResultSrcE = i.rsrc;
    bus.RegWriteM = i.rwm; bus.RegWriteW = i.rww; bus.PCSrcE = i.pcs;
    bus.MemReqM = i.req; bus.MemAckM = i.ack;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check control/busy/timeout just before the clock edge, then advance.
  task automatic step(input string name, input in_t i, input logic [6:0] e_ctl,
                      input logic e_busy, input logic e_to);
    apply(i);
    #2;
    chk({name, "_ctl"}, 32'(ctl()), 32'(e_ctl));
    chk({name, "_busy"}, 32'(bus.MemBusy), 32'(e_busy));
    chk({name, "_timeout"}, 32'(bus.MemTimeout), 32'(e_to));
    cyc();
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs, input in_t i);
    if (i.rwm && i.rdm != 0 && i.rdm == rs) return 2'b10;
    if (i.rww && i.rdw != 0 && i.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic vec_t mkv(input string n, input in_t i, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [6:0] c);
    vec_t r;
    r.name = n; r.in = i; r.fa = fa; r.fb = fb; r.ctl = c;
    return r;
  endfunction

  initial begin
    idle = '{default: 0};
    rst  = 1'b1;
    apply(idle);
    cyc();

    // Reset behaviour with matching forwarding inputs present
    v = '{default: 0, rs1e: 5, rdm: 5, rwm: 1};
    apply(v);
    #2;
    chk("rst_ctl", 32'(ctl()), 32'(C_RST));
    chk("rst_fwd_a", 32'(bus.ForwardAE), 32'(2'b00));
    cyc();
    rst = 1'b0;
    step("post_rst", idle, C_NONE, 1'b0, 1'b0);

    // Directed combinational vectors (memory FSM idle)
    tbl.push_back(mkv("fwd_m_wins", '{default: 0, rs1e: 5, rdm: 5, rdw: 5, rwm: 1, rww: 1}, 2'b10, 2'b00, C_NONE));
    tbl.push_back(mkv("fwd_w_only", '{default: 0, rs1e: 5, rdm: 5, rdw: 5, rwm: 0, rww: 1}, 2'b01, 2'b00, C_NONE));
    tbl.push_back(mkv("fwd_x0", '{default: 0, rs1e: 0, rdm: 0, rdw: 0, rwm: 1, rww: 1}, 2'b00, 2'b00, C_NONE));
    tbl.push_back(mkv("fwd_a_m_b_w", '{default: 0, rs1e: 3, rs2e: 9, rdm: 3, rdw: 9, rwm: 1, rww: 1}, 2'b10, 2'b01, C_NONE));
    tbl.push_back(mkv("fwd_both_m", '{default: 0, rs1e: 4, rs2e: 4, rdm: 4, rwm: 1}, 2'b10, 2'b10, C_NONE));
    tbl.push_back(mkv("fwd_nowrite", '{default: 0, rs1e: 6, rs2e: 6, rdm: 6, rdw: 6}, 2'b00, 2'b00, C_NONE));
    tbl.push_back(mkv("lw_rs2", '{default: 0, rsrc: 2'b01, rde: 7, rs2d: 7}, 2'b00, 2'b00, C_LW));
    tbl.push_back(mkv("lw_rs1", '{default: 0, rsrc: 2'b01, rde: 12, rs1d: 12}, 2'b00, 2'b00, C_LW));
    tbl.push_back(mkv("lw_rd0", '{default: 0, rsrc: 2'b01, rde: 0, rs2d: 0}, 2'b00, 2'b00, C_NONE));
    tbl.push_back(mkv("nonload", '{default: 0, rsrc: 2'b10, rde: 7, rs2d: 7}, 2'b00, 2'b00, C_NONE));
    tbl.push_back(mkv("br_over_lw", '{default: 0, rsrc: 2'b01, rde: 7, rs2d: 7, pcs: 1}, 2'b00, 2'b00, C_BR));
    tbl.push_back(mkv("br_only", '{default: 0, pcs: 1}, 2'b00, 2'b00, C_BR));
    tbl.push_back(mkv("single_cycle_mem", '{default: 0, req: 1, ack: 1}, 2'b00, 2'b00, C_NONE));

    foreach (tbl[k]) begin
      apply(tbl[k].in);
      #2;
      chk({tbl[k].name, "_fa"}, 32'(bus.ForwardAE), 32'(tbl[k].fa));
      chk({tbl[k].name, "_fb"}, 32'(bus.ForwardBE), 32'(tbl[k].fb));
      chk({tbl[k].name, "_ctl"}, 32'(ctl()), 32'(tbl[k].ctl));
      cyc();
    end

    // Multi-cycle access: three stall cycles, released in the ack cycle
    v = '{default: 0, req: 1};
    step("mc_c1", v, C_MEM, 1'b0, 1'b0);
    step("mc_c2", v, C_MEM, 1'b1, 1'b0);
    step("mc_c3", v, C_MEM, 1'b1, 1'b0);
    v.ack = 1;
    step("mc_ack", v, C_NONE, 1'b1, 1'b0);
    step("mc_idle", idle, C_NONE, 1'b0, 1'b0);

    // Same with a taken branch in E: the flush waits for the release
    v = '{default: 0, req: 1, pcs: 1};
    step("mcbr_c1", v, C_MEM, 1'b0, 1'b0);
    step("mcbr_c2", v, C_MEM, 1'b1, 1'b0);
    step("mcbr_c3", v, C_MEM, 1'b1, 1'b0);
    v.ack = 1;
    step("mcbr_ack", v, C_BR, 1'b1, 1'b0);
    step("mcbr_idle", idle, C_NONE, 1'b0, 1'b0);

    // Ack while the counter sits at TIMEOUT_CYCLES still completes
    v = '{default: 0, req: 1};
    for (int unsigned c = 0; c <= TO; c++) begin
      if (c == TO) v.ack = 1;
      step("edge_ack", v, (c == TO) ? C_NONE : C_MEM, c != 0, 1'b0);
    end
    step("edge_idle", idle, C_NONE, 1'b0, 1'b0);

    // No ack: watchdog fires, pipeline frozen, late ack ignored
    v = '{default: 0, req: 1};
    for (int unsigned c = 0; c <= TO; c++)
      step("to_wait", v, C_MEM, c != 0, 1'b0);
    step("to_err", v, C_MEM, 1'b1, 1'b1);
    v.ack = 1;
    step("to_late_ack", v, C_MEM, 1'b1, 1'b1);
    step("to_hold", idle, C_MEM, 1'b1, 1'b1);
    rst = 1'b1;
    apply(idle);
    #2;
    chk("to_rst_ctl", 32'(ctl()), 32'(C_RST));
    cyc();
    rst = 1'b0;
    step("to_cleared", idle, C_NONE, 1'b0, 1'b0);

    // Reset in the middle of a wait aborts the access
    v = '{default: 0, req: 1};
    step("rw_c1", v, C_MEM, 1'b0, 1'b0);
    step("rw_c2", v, C_MEM, 1'b1, 1'b0);
    rst = 1'b1;
    v = '{default: 0, req: 1, rs1e: 2, rs2e: 3, rdm: 2, rdw: 3, rwm: 1, rww: 1};
    apply(v);
    #2;
    chk("rw_rst_ctl", 32'(ctl()), 32'(C_RST));
    chk("rw_rst_fa", 32'(bus.ForwardAE), 32'(2'b00));
    chk("rw_rst_fb", 32'(bus.ForwardBE), 32'(2'b00));
    cyc();
    rst = 1'b0;
    step("rw_after", idle, C_NONE, 1'b0, 1'b0);

    // Random traffic against the reference model
    waited = 0;
    dead   = 0;
    for (int n = 0; n < 1500; n++) begin
      logic       ms, lw, e_busy;
      logic [6:0] e_ctl;
      logic [1:0] e_fa, e_fb;
      v.rs1d = AW'($urandom_range(0, 3)); v.rs2d = AW'($urandom_range(0, 3));
      v.rs1e = AW'($urandom_range(0, 3)); v.rs2e = AW'($urandom_range(0, 3));
      v.rde  = AW'($urandom_range(0, 3)); v.rdm  = AW'($urandom_range(0, 3));
      v.rdw  = AW'($urandom_range(0, 3)); v.rsrc = 2'($urandom_range(0, 3));
      v.rwm  = 1'($urandom_range(0, 1));  v.rww  = 1'($urandom_range(0, 1));
      v.pcs  = ($urandom_range(0, 3) == 0);
      v.req  = 1'($urandom_range(0, 1));
      v.ack  = ($urandom_range(0, 2) == 0);
      rst    = ($urandom_range(0, 24) == 0);
      apply(v);
      #2;

      ms = dead ? 1'b1 : (waited > 0) ? !v.ack : (v.req && !v.ack);
      lw = (v.rsrc == 2'b01) && (v.rde != 0) && (v.rde == v.rs1d || v.rde == v.rs2d);
      if (rst)       e_ctl = C_RST;
      else if (ms)   e_ctl = C_MEM;
      else if (v.pcs) e_ctl = C_BR;
      else if (lw)   e_ctl = C_LW;
      else           e_ctl = C_NONE;
      e_fa   = rst ? 2'b00 : ref_fwd(v.rs1e, v);
      e_fb   = rst ? 2'b00 : ref_fwd(v.rs2e, v);
      e_busy = !rst && (waited > 0 || dead);

      chk("rand_ctl", 32'(ctl()), 32'(e_ctl));
      chk("rand_fa", 32'(bus.ForwardAE), 32'(e_fa));
      chk("rand_fb", 32'(bus.ForwardBE), 32'(e_fb));
      chk("rand_busy", 32'(bus.MemBusy), 32'(e_busy));
      chk("rand_timeout", 32'(bus.MemTimeout), 32'(dead));

      if (rst) begin
        waited = 0;
        dead   = 0;
      end else if (!dead) begin
        if (waited > 0) begin
          if (v.ack)             waited = 0;
          else if (waited == TO) dead = 1;
          else                   waited++;
        end else if (v.req && !v.ack) begin
          waited = 1;
        end
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
